// File: rtl/block_unpacker.sv
// block_unpacker: splits wide multi-block words into a narrower block stream.
// A held word is walked from block 0 upward, OUT_BLOCKS blocks per beat.
module block_unpacker #(
  parameter int unsigned BLOCK_SIZE = 64,
  parameter int unsigned IN_BLOCKS  = 4,
  parameter int unsigned OUT_BLOCKS = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             in_ready,
  input  logic [IN_BLOCKS*BLOCK_SIZE-1:0]  in_data,
  input  logic                             in_valid,
  input  logic [31:0]                      in_num,
  input  logic                             in_last,
  input  logic                             ready_4_output,
  output logic [OUT_BLOCKS*BLOCK_SIZE-1:0] out_data,
  output logic                             out_valid,
  output logic [31:0]                      out_num,
  output logic                             out_last
);

  localparam int unsigned IN_W = IN_BLOCKS * BLOCK_SIZE;
  localparam int unsigned CW   = $clog2(IN_BLOCKS + 1);
  localparam logic [CW-1:0] OB_C = CW'(OUT_BLOCKS);
  localparam logic [CW-1:0] IB_C = CW'(IN_BLOCKS);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e          state_q, state_d;
  logic [IN_W-1:0] data_q, data_d;
  logic            last_q, last_d;
  logic [CW-1:0]   rem_q, rem_d;
  logic [CW-1:0]   off_q, off_d;
  logic            live_q;

  logic            final_c;
  logic            in_hs_c;
  logic            out_hs_c;
  logic [CW-1:0]   n_c;
  logic [CW-1:0]   beat_num_c;

  // Clamp the incoming block count to the word capacity.
  assign n_c = (in_num > 32'(IN_BLOCKS)) ? IB_C : in_num[CW-1:0];

  // Beat bookkeeping derived from held position.
  assign final_c    = (rem_q <= OB_C);
  assign beat_num_c = final_c ? rem_q : OB_C;

  // Outputs muxed purely from registered state; in_ready is the one comb path.
  assign out_valid = (state_q == SEND);
  assign out_num   = 32'(beat_num_c);
  assign out_last  = out_valid & last_q & final_c;
  assign in_ready  = live_q & ((state_q == IDLE) | (final_c & ready_4_output));
  assign in_hs_c   = in_valid & in_ready;
  assign out_hs_c  = out_valid & ready_4_output;

  // Select the current chunk; slots past the remaining count read as zero.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < int'(OUT_BLOCKS); j++) begin
      if ((j < int'(rem_q)) && ((int'(off_q) + j) < int'(IN_BLOCKS))) begin
        out_data[j*BLOCK_SIZE +: BLOCK_SIZE] =
          data_q[(int'(off_q) + j)*BLOCK_SIZE +: BLOCK_SIZE];
      end
    end
  end

  // Next-state: advance on output handshake, reload on input handshake.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    last_d  = last_q;
    rem_d   = rem_q;
    off_d   = off_q;
    case (state_q)
      IDLE: state_d = IDLE;
      SEND: begin
        if (out_hs_c) begin
          rem_d = rem_q - beat_num_c;
          off_d = off_q + OB_C;
          if (final_c) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A zero-block non-final word is swallowed without producing a beat.
    if (in_hs_c) begin
      data_d  = in_data;
      last_d  = in_last;
      rem_d   = n_c;
      off_d   = '0;
      state_d = ((n_c == '0) && !in_last) ? IDLE : SEND;
    end
  end

  // State registers; live_q holds off in_ready until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      last_q  <= 1'b0;
      rem_q   <= '0;
      off_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      off_q   <= off_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_block_unpacker.sv
// Bench for block_unpacker: directed stimulus on a 4->1 and a 4->2 instance,
// with a beat-list scoreboard built from the unpacking rules.
module tb_block_unpacker;

  localparam logic [63:0] A = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] B = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] C = 64'hCCCC_0000_0000_0003;
  localparam logic [63:0] D = 64'hDDDD_0000_0000_0004;
  localparam logic [63:0] E = 64'hEEEE_0000_0000_0005;
  localparam logic [63:0] F = 64'hFFFF_0000_0000_0006;
  localparam logic [63:0] G = 64'h1111_0000_0000_0007;
  localparam logic [63:0] H = 64'h2222_0000_0000_0008;
  localparam logic [63:0] I = 64'h3333_0000_0000_0009;
  localparam logic [63:0] J = 64'h4444_0000_0000_000A;

  typedef struct packed {
    logic [127:0] data;
    logic [31:0]  num;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         rdy0, vin0, last0, r4o0, vout0, lout0;
  logic [255:0] din0;
  logic [31:0]  num0, nout0;
  logic [63:0]  dout0;

  logic         rdy1, vin1, last1, r4o1, vout1, lout1;
  logic [255:0] din1;
  logic [31:0]  num1, nout1;
  logic [127:0] dout1;

  block_unpacker #(.BLOCK_SIZE(64), .IN_BLOCKS(4), .OUT_BLOCKS(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_ready(rdy0), .in_data(din0), .in_valid(vin0),
    .in_num(num0), .in_last(last0), .ready_4_output(r4o0), .out_data(dout0),
    .out_valid(vout0), .out_num(nout0), .out_last(lout0)
  );

  block_unpacker #(.BLOCK_SIZE(64), .IN_BLOCKS(4), .OUT_BLOCKS(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_ready(rdy1), .in_data(din1), .in_valid(vin1),
    .in_num(num1), .in_last(last1), .ready_4_output(r4o1), .out_data(dout1),
    .out_valid(vout1), .out_num(nout1), .out_last(lout1)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  beat_t q0[$];
  beat_t q1[$];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected beat list for one accepted word: clamp, then slice in OUT_BLOCKS chunks.
  task automatic expand(input int k, input logic [255:0] d, input logic [31:0] num,
                        input logic last, input int ob);
    int    n;
    int    nb;
    beat_t e;
    n = (num > 32'd4) ? 4 : int'(num);
    if (n == 0) begin
      if (last) begin
        e = '{data: '0, num: 32'd0, last: 1'b1};
        if (k == 0) q0.push_back(e); else q1.push_back(e);
      end
      return;
    end
    nb = (n + ob - 1) / ob;
    for (int b = 0; b < nb; b++) begin
      e.data = '0;
      for (int j = 0; j < ob; j++)
        if (b*ob + j < n) e.data[j*64 +: 64] = d[(b*ob + j)*64 +: 64];
      e.num  = 32'((n - b*ob < ob) ? (n - b*ob) : ob);
      e.last = last && (b == nb - 1);
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic score(input int k, input logic vout, input logic [127:0] dout,
                       input logic [31:0] nout, input logic lout, input logic r4o);
    beat_t e;
    int    sz;
    sz = (k == 0) ? q0.size() : q1.size();
    if (vout) begin
      if (sz == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb%0d_unexpected_beat: got data %0h expected no beat", k, dout);
      end else begin
        if (k == 0) e = q0[0]; else e = q1[0];
        chk($sformatf("sb%0d_data", k), dout, e.data);
        chk($sformatf("sb%0d_num", k), 128'(nout), 128'(e.num));
        chk($sformatf("sb%0d_last", k), 128'(lout), 128'(e.last));
        if (r4o) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end else if (sz != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb%0d_bubble: got out_valid 0 expected 1 with %0d beats pending", k, sz);
    end
  endtask

  // Compare process: check outputs, then record any word accepted at the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      score(0, vout0, 128'(dout0), nout0, lout0, r4o0);
      score(1, vout1, dout1, nout1, lout1, r4o1);
      if (vin0 && rdy0) expand(0, din0, num0, last0, 1);
      if (vin1 && rdy1) expand(1, din1, num1, last1, 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int beats;
    rst = 1'b1;
    vin0 = 0; din0 = '0; num0 = '0; last0 = 0; r4o0 = 0;
    vin1 = 0; din1 = '0; num1 = '0; last1 = 0; r4o1 = 0;
    #2;
    chk("rst_out_valid", 128'(vout0), 128'(0));
    chk("rst_in_ready", 128'(rdy0), 128'(0));
    chk("rst_out_data", 128'(dout0), 128'(0));
    chk("rst_out_num", 128'(nout0), 128'(0));
    chk("rst_out_last", 128'(lout0), 128'(0));
    chk("rst_in_ready1", 128'(rdy1), 128'(0));
    tick(); tick();
    rst = 1'b0;
    chk("post_rst_ready_low", 128'(rdy0), 128'(0));
    tick();
    chk("post_rst_ready_high", 128'(rdy0), 128'(1));

    // Basic unpack
    r4o0 = 1; din0 = {D, C, B, A}; num0 = 3; last0 = 1; vin0 = 1;
    chk("basic_ready_idle", 128'(rdy0), 128'(1));
    tick(); vin0 = 0;
    chk("basic_A", 128'(dout0), 128'(A));
    chk("basic_A_num", 128'(nout0), 128'(1));
    chk("basic_A_last", 128'(lout0), 128'(0));
    chk("basic_A_ready", 128'(rdy0), 128'(0));
    tick();
    chk("basic_B", 128'(dout0), 128'(B));
    chk("basic_B_last", 128'(lout0), 128'(0));
    chk("basic_B_ready", 128'(rdy0), 128'(0));
    tick();
    chk("basic_C", 128'(dout0), 128'(C));
    chk("basic_C_last", 128'(lout0), 128'(1));
    chk("basic_C_ready", 128'(rdy0), 128'(1));
    tick();
    chk("basic_done", 128'(vout0), 128'(0));

    // Backpressure on beat B
    din0 = {D, C, B, A}; num0 = 3; last0 = 1; vin0 = 1;
    tick(); vin0 = 0;
    chk("bp_A", 128'(dout0), 128'(A));
    tick(); r4o0 = 0;
    chk("bp_B1", 128'(dout0), 128'(B));
    tick();
    chk("bp_B2", 128'(dout0), 128'(B));
    chk("bp_B2_num", 128'(nout0), 128'(1));
    chk("bp_B2_last", 128'(lout0), 128'(0));
    tick(); r4o0 = 1;
    chk("bp_B3", 128'(dout0), 128'(B));
    tick();
    chk("bp_C", 128'(dout0), 128'(C));
    chk("bp_C_last", 128'(lout0), 128'(1));
    tick();
    chk("bp_done", 128'(vout0), 128'(0));

    // Back-to-back words, second accepted with the final beat of the first
    din0 = {64'd0, 64'd0, B, A}; num0 = 2; last0 = 0; vin0 = 1;
    tick(); vin0 = 0;
    chk("b2b_A", 128'(dout0), 128'(A));
    chk("b2b_A_ready", 128'(rdy0), 128'(0));
    tick();
    din0 = {64'd0, 64'd0, 64'd0, C}; num0 = 1; last0 = 1; vin0 = 1;
    chk("b2b_B", 128'(dout0), 128'(B));
    chk("b2b_B_last", 128'(lout0), 128'(0));
    chk("b2b_B_ready", 128'(rdy0), 128'(1));
    tick(); vin0 = 0;
    chk("b2b_C_valid", 128'(vout0), 128'(1));
    chk("b2b_C", 128'(dout0), 128'(C));
    chk("b2b_C_last", 128'(lout0), 128'(1));
    tick();
    chk("b2b_done", 128'(vout0), 128'(0));

    // Zero-count words
    din0 = {D, C, B, A}; num0 = 0; last0 = 0; vin0 = 1;
    chk("zero_ready", 128'(rdy0), 128'(1));
    tick(); vin0 = 0;
    chk("zero_drop_valid", 128'(vout0), 128'(0));
    chk("zero_drop_ready", 128'(rdy0), 128'(1));
    num0 = 0; last0 = 1; vin0 = 1;
    tick(); vin0 = 0;
    chk("zero_last_valid", 128'(vout0), 128'(1));
    chk("zero_last_num", 128'(nout0), 128'(0));
    chk("zero_last_data", 128'(dout0), 128'(0));
    chk("zero_last_last", 128'(lout0), 128'(1));
    tick();
    chk("zero_last_done", 128'(vout0), 128'(0));

    // Wide output on the 4->2 instance
    r4o1 = 1; din1 = {D, C, B, A}; num1 = 3; last1 = 1; vin1 = 1;
    tick(); vin1 = 0;
    chk("wide_AB", dout1, {B, A});
    chk("wide_AB_num", 128'(nout1), 128'(2));
    chk("wide_AB_last", 128'(lout1), 128'(0));
    tick();
    chk("wide_C0", dout1, {64'd0, C});
    chk("wide_C0_num", 128'(nout1), 128'(1));
    chk("wide_C0_last", 128'(lout1), 128'(1));
    tick();
    chk("wide_done", 128'(vout1), 128'(0));

    // Clamp: in_num=7 yields exactly four beats
    din0 = {D, C, B, A}; num0 = 7; last0 = 1; vin0 = 1;
    tick(); vin0 = 0;
    beats = 0;
    for (int i = 0; i < 10; i++) begin
      if (vout0) beats++;
      tick();
    end
    chk("clamp_beats", 128'(beats), 128'(4));

    // Reset during the second beat
    din0 = {H, G, F, E}; num0 = 4; last0 = 1; vin0 = 1;
    tick(); vin0 = 0;
    chk("rst_mid_E", 128'(dout0), 128'(E));
    tick();
    chk("rst_mid_F", 128'(dout0), 128'(F));
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 128'(vout0), 128'(0));
    chk("rst_mid_ready", 128'(rdy0), 128'(0));
    chk("rst_mid_data", 128'(dout0), 128'(0));
    tick();
    rst = 1'b0;
    chk("rst_mid_ready_low", 128'(rdy0), 128'(0));
    tick();
    chk("rst_mid_ready_high", 128'(rdy0), 128'(1));
    din0 = {64'd0, 64'd0, J, I}; num0 = 2; last0 = 1; vin0 = 1;
    tick(); vin0 = 0;
    chk("after_rst_I", 128'(dout0), 128'(I));
    chk("after_rst_I_num", 128'(nout0), 128'(1));
    tick();
    chk("after_rst_J", 128'(dout0), 128'(J));
    chk("after_rst_J_last", 128'(lout0), 128'(1));
    tick();
    chk("after_rst_done", 128'(vout0), 128'(0));

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_unpacker.md
# block_unpacker

Unpacks wide multi-block words into a narrow block stream, doing the reverse of the block packing stage. Each input word carries up to IN_BLOCKS blocks plus a block count. The block emits those blocks downstream in chunks of up to OUT_BLOCKS per beat, with a valid/ready handshake on both sides. It sits between a packed-block producer and a consumer that handles fewer blocks per cycle.

## Interface
- BLOCK_SIZE, 64, width in bits of one block
- IN_BLOCKS, 4, maximum blocks per input word
- OUT_BLOCKS, 1, maximum blocks per output beat; IN_BLOCKS must be a multiple of OUT_BLOCKS
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_ready  out  1  unpacker can accept an input word this cycle
- in_data  in  IN_BLOCKS*BLOCK_SIZE  packed blocks; block i is in_data[i*BLOCK_SIZE +: BLOCK_SIZE]
- in_valid  in  1  input word valid
- in_num  in  32  number of valid blocks in in_data, packed from block 0 upward
- in_last  in  1  word is the final word of the stream
- ready_4_output  in  1  downstream accepts the current beat
- out_data  out  OUT_BLOCKS*BLOCK_SIZE  output chunk; unused block slots are zero
- out_valid  out  1  output beat valid
- out_num  out  32  valid blocks in this beat, 0..OUT_BLOCKS
- out_last  out  1  final beat of the stream

## Operation
- Input handshake: in_valid & in_ready. Output handshake: out_valid & ready_4_output.
- State machine has two states, IDLE and SEND.
- **IDLE:**
  - in_ready=1, out_valid=0.
  - On input handshake, latch in_data, in_last and n = min(in_num, IN_BLOCKS). Set remaining=n and offset=0.
  - n=0 with in_last=0: word is dropped and the state stays IDLE.
  - n=0 with in_last=1: go to SEND. One beat is emitted with out_num=0, out_data=0, out_last=1.
  - n>0: go to SEND.
- **SEND:**
  - out_valid=1.
  - out_data = held blocks [offset, offset+OUT_BLOCKS); slots at index ≥ offset+remaining are zero.
  - out_num = min(remaining, OUT_BLOCKS).
  - out_last = held_last & (remaining ≤ OUT_BLOCKS).
  - On output handshake: remaining -= out_num, offset += OUT_BLOCKS.
  - If that beat was the final one (remaining ≤ OUT_BLOCKS), go to IDLE, unless a new word is accepted in the same cycle.
- **Same-cycle accept:**
  - In SEND, in_ready = final beat & ready_4_output. This is the only combinational path, from ready_4_output to in_ready.
  - A word accepted this way is latched and processed as in IDLE. The state stays SEND, or goes to IDLE if the new word is dropped (n=0, in_last=0).
- **Stability:** while out_valid=1 and ready_4_output=0, out_data, out_num and out_last hold stable.
- **Width rules:**
  - remaining and offset are $clog2(IN_BLOCKS+1) bits wide.
  - out_num is zero-extended to 32 bits.
  - in_num above IN_BLOCKS is clamped and no error is flagged.

## Timing
- **Reset values:** while rst is high, out_valid=0, out_data=0, out_num=0, out_last=0 and in_ready=0. State is IDLE, with remaining=0 and offset=0.
- **Reset mid-word:** assertion takes effect immediately and discards the held word and its position. in_ready rises on the first clk edge after rst deasserts.
- **Latency:** a word accepted at edge t gives its first beat valid after edge t, i.e. in cycle t+1.
- **Throughput:**
  - A word of n>0 blocks occupies ceil(n/OUT_BLOCKS) beats.
  - Back-to-back words with ready_4_output held high produce no bubble beats.
  - A dropped zero-block word costs one accept cycle in IDLE.
- All outputs except in_ready are registered, or muxed purely from registered state.

## Test plan
- **Basic unpack** (IN_BLOCKS=4, OUT_BLOCKS=1): in_num=3, blocks A,B,C, in_last=1, ready held high.
  - Beats A,B,C in consecutive cycles, each with out_num=1.
  - out_last=1 only on C.
  - in_ready=0 during beats A and B, and 1 during beat C.
- **Backpressure:** ready_4_output=0 for 2 cycles while beat B is presented.
  - B stays stable for 3 cycles.
  - C follows, with no block lost or duplicated.
- **Back-to-back:** word1 with in_num=2 (A,B), last=0, then word2 with in_num=1 (C), last=1, ready high.
  - Output is A,B,C on three consecutive cycles.
  - word2 is accepted in the same cycle B completes.
  - out_last=1 on C only.
- **Zero-count words:**
  - in_num=0, last=0: no output beat, and in_ready stays 1.
  - in_num=0, last=1: exactly one beat with out_num=0, out_data=0, out_last=1.
- **Wide output** (OUT_BLOCKS=2): in_num=3 (A,B,C).
  - Beat 1 is {A,B} with out_num=2.
  - Beat 2 is {C,0} with out_num=1.
- **Clamp and reset:**
  - in_num=7 with IN_BLOCKS=4 gives exactly 4 beats.
  - Asserting rst during beat 2 drives out_valid to 0 before the next edge.
  - After deassertion, the next word unpacks from block 0.
